lc4_phase_mem_sequencer: RTL and testbench

- Consumer side of the four-phase enable scheme (i1re, i2re, dre, gwe).
- Time-multiplexes one single-ported memory between two instruction-fetch ports and one data port.
- Captures each phase's read data, then publishes a coherent frame to the core on the gwe phase.
- Commits data writes only in gwe, and checks that the strobe sequence is legal.

---
 rtl/lc4_phase_mem_sequencer_pkg.sv | 38 +++
 rtl/lc4_phase_tracker.sv | 109 ++++++++++
 rtl/lc4_phase_mem_sequencer.sv | 120 ++++++++++++
 tb/tb_lc4_phase_mem_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_phase_mem_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lc4_phase_mem_sequencer_pkg
// Shared definitions for the four-phase memory sequencer:
//   - phase FSM state encoding (3-bit codes and the enum built on them)
//   - packed strobe bundle {i1re, i2re, dre, gwe}
//   - strobe-legality helper (exactly one strobe high)
// -----------------------------------------------------------------------------
package lc4_phase_mem_sequencer_pkg;

  localparam logic [2:0] ST_UNSYNC = 3'd0;
  localparam logic [2:0] ST_EXP_I1 = 3'd1;
  localparam logic [2:0] ST_EXP_I2 = 3'd2;
  localparam logic [2:0] ST_EXP_D  = 3'd3;
  localparam logic [2:0] ST_EXP_G  = 3'd4;

  typedef enum logic [2:0] {
    UNSYNC = ST_UNSYNC,
    EXP_I1 = ST_EXP_I1,
    EXP_I2 = ST_EXP_I2,
    EXP_D  = ST_EXP_D,
    EXP_G  = ST_EXP_G
  } phase_state_e;

  typedef struct packed {
    logic i1re;
    logic i2re;
    logic dre;
    logic gwe;
  } strobes_t;

  // True when exactly one strobe is high (non-zero and a power of two).
  function automatic logic strobes_legal(input strobes_t stb);
    logic [3:0] v;
    v = stb;
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/lc4_phase_tracker.sv
// -----------------------------------------------------------------------------
// lc4_phase_tracker
// Phase-sequence FSM: follows the i1re -> i2re -> dre -> gwe strobe cycle,
// flags illegal or out-of-order cycles, and tells the parent which phase (if
// any) is being accepted this cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stb_i         current strobe bundle
//   cap_i1_o      accepted lone i1re (capture instruction 1 this edge)
//   cap_i2_o      accepted lone i2re (capture instruction 2 this edge)
//   cap_d_o       accepted lone dre  (capture data read this edge)
//   commit_o      accepted lone gwe in EXP_G (publish / allow write)
//   in_sync_o     FSM is tracking a legal sequence
//   seq_err_o     sticky sequence-error flag
// -----------------------------------------------------------------------------
module lc4_phase_tracker
  import lc4_phase_mem_sequencer_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  strobes_t stb_i,
  output logic     cap_i1_o,
  output logic     cap_i2_o,
  output logic     cap_d_o,
  output logic     commit_o,
  output logic     in_sync_o,
  output logic     seq_err_o
);

  phase_state_e state_q, state_d;
  logic         seq_err_q;
  logic         set_err;
  logic         lone;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    lone     = strobes_legal(stb_i);
    state_d  = state_q;
    set_err  = 1'b0;
    cap_i1_o = 1'b0;
    cap_i2_o = 1'b0;
    cap_d_o  = 1'b0;
    commit_o = 1'b0;
    unique case (state_q)
      // While unsynchronised, only a lone i1re matters; anything else is
      // simply waited out without raising an error.
      UNSYNC: begin
        if (lone && stb_i.i1re) begin
          state_d  = EXP_I2;
          cap_i1_o = 1'b1;
        end
      end
      EXP_I1: begin
        if (lone && stb_i.i1re) begin
          state_d  = EXP_I2;
          cap_i1_o = 1'b1;
        end else begin
          state_d = UNSYNC;
          set_err = 1'b1;
        end
      end
      EXP_I2: begin
        if (lone && stb_i.i2re) begin
          state_d  = EXP_D;
          cap_i2_o = 1'b1;
        end else begin
          state_d = UNSYNC;
          set_err = 1'b1;
        end
      end
      EXP_D: begin
        if (lone && stb_i.dre) begin
          state_d = EXP_G;
          cap_d_o = 1'b1;
        end else begin
          state_d = UNSYNC;
          set_err = 1'b1;
        end
      end
      EXP_G: begin
        if (lone && stb_i.gwe) begin
          state_d  = EXP_I1;
          commit_o = 1'b1;
        end else begin
          state_d = UNSYNC;
          set_err = 1'b1;
        end
      end
      default: state_d = UNSYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNSYNC;
      seq_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_err) seq_err_q <= 1'b1;
    end
  end

  assign in_sync_o = (state_q != UNSYNC);
  assign seq_err_o = seq_err_q;

endmodule

// File: rtl/lc4_phase_mem_sequencer.sv
// -----------------------------------------------------------------------------
// lc4_phase_mem_sequencer
// Shares one asynchronous-read, single-port memory between two instruction
// fetch ports and one data port using the i1re/i2re/dre/gwe phase strobes.
// Each accepted phase's read data is held in a shadow register; on the gwe
// phase the whole frame is published at once and the data write is committed.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i1re, i2re, dre, gwe         phase strobes
//   i1_addr, i2_addr, d_addr     port addresses
//   d_we, d_wdata                data write request/data (used in gwe phase)
//   mem_addr, mem_we, mem_wdata  memory request (combinational)
//   mem_rdata                    memory read data (same-cycle)
//   i1_data, i2_data, d_rdata    published frame
//   frame_valid                  one-cycle pulse per published frame
//   in_sync, seq_err             tracker status (seq_err is sticky)
//   frame_cnt                    published-frame counter (wraps)
// -----------------------------------------------------------------------------
module lc4_phase_mem_sequencer
  import lc4_phase_mem_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i1re,
  input  logic              i2re,
  input  logic              dre,
  input  logic              gwe,
  input  logic [ADDR_W-1:0] i1_addr,
  input  logic [ADDR_W-1:0] i2_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] i1_data,
  output logic [DATA_W-1:0] i2_data,
  output logic [DATA_W-1:0] d_rdata,
  output logic              frame_valid,
  output logic              in_sync,
  output logic              seq_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  strobes_t stb;
  logic     cap_i1, cap_i2, cap_d, commit;

  logic [DATA_W-1:0] sh_i1_q, sh_i2_q, sh_d_q;
  logic [DATA_W-1:0] i1_data_q, i2_data_q, d_rdata_q;
  logic              frame_valid_q;
  logic [FCNT_W-1:0] frame_cnt_q;

  assign stb = '{i1re: i1re, i2re: i2re, dre: dre, gwe: gwe};

  lc4_phase_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .stb_i     (stb),
    .cap_i1_o  (cap_i1),
    .cap_i2_o  (cap_i2),
    .cap_d_o   (cap_d),
    .commit_o  (commit),
    .in_sync_o (in_sync),
    .seq_err_o (seq_err)
  );

  // Address mux: priority i1re > i2re > dre > gwe; idle cycles park on i1_addr.
  always_comb begin
    mem_addr = i1_addr;
    if (i1re)      mem_addr = i1_addr;
    else if (i2re) mem_addr = i2_addr;
    else if (dre)  mem_addr = d_addr;
    else if (gwe)  mem_addr = d_addr;
  end

  // commit already implies a lone gwe in EXP_G; rst blocks the write outright
  // so a reset landing in the gwe phase cannot corrupt memory.
  assign mem_we    = commit & d_we & ~rst;
  assign mem_wdata = d_wdata;

  // NOTE: shadow and published registers are reset explicitly so the first
  // frame after reset can never expose stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_i1_q       <= '0;
      sh_i2_q       <= '0;
      sh_d_q        <= '0;
      i1_data_q     <= '0;
      i2_data_q     <= '0;
      d_rdata_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      if (cap_i1) sh_i1_q <= mem_rdata;
      if (cap_i2) sh_i2_q <= mem_rdata;
      if (cap_d)  sh_d_q  <= mem_rdata;
      frame_valid_q <= commit;
      // sh_d_q was captured in the dre phase, before this gwe write lands,
      // so a same-address read/write frame publishes the old value.
      if (commit) begin
        i1_data_q   <= sh_i1_q;
        i2_data_q   <= sh_i2_q;
        d_rdata_q   <= sh_d_q;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign i1_data     = i1_data_q;
  assign i2_data     = i2_data_q;
  assign d_rdata     = d_rdata_q;
  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_lc4_phase_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lc4_phase_mem_sequencer
// Self-checking bench: a small behavioural memory, a reference copy of its
// contents, a table of single-cycle strobe vectors, and hand-written frame
// sequences. Published frames are predicted into a queue when the gwe phase
// is driven and compared when frame_valid appears.
// -----------------------------------------------------------------------------
module tb_lc4_phase_mem_sequencer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int FCNT_W = 8;

  typedef struct {
    logic [15:0] i1;
    logic [15:0] i2;
    logic [15:0] d;
    logic [7:0]  cnt;
  } pub_t;

  typedef struct {
    logic [3:0]  stb;      // {i1re, i2re, dre, gwe}
    logic        dwe;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic        exp_sync; // after the edge
    logic        exp_err;  // after the edge
    logic        pub;      // a frame is published by this edge
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [3:0]        stb;
  logic [ADDR_W-1:0] i1a, i2a, da;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] i1_data, i2_data, d_rdata;
  logic              frame_valid, in_sync, seq_err;
  logic [FCNT_W-1:0] frame_cnt;

  lc4_phase_mem_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FCNT_W(FCNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i1re        (stb[3]),
    .i2re        (stb[2]),
    .dre         (stb[1]),
    .gwe         (stb[0]),
    .i1_addr     (i1a),
    .i2_addr     (i2a),
    .d_addr      (da),
    .d_we        (d_we),
    .d_wdata     (d_wdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .i1_data     (i1_data),
    .i2_data     (i2_data),
    .d_rdata     (d_rdata),
    .frame_valid (frame_valid),
    .in_sync     (in_sync),
    .seq_err     (seq_err),
    .frame_cnt   (frame_cnt)
  );

  // Behavioural memory (async read) and the bench's own reference copy.
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  pub_t sb[$];
  pub_t last_pub;
  logic [7:0] exp_cnt;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every frame_valid must match the oldest prediction.
  always @(negedge clk) begin
    pub_t e;
    if (frame_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame_valid: got frame_valid=1 expected 0 (cnt %h)", frame_cnt);
      end else begin
        e = sb.pop_front();
        check("pub_i1_data", 32'(i1_data), 32'(e.i1));
        check("pub_i2_data", 32'(i2_data), 32'(e.i2));
        check("pub_d_rdata", 32'(d_rdata), 32'(e.d));
        check("pub_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      end
    end
  end

  // Predict the frame formed from the current addresses (reads before write).
  task automatic push_expected();
    pub_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.i1  = ref_mem[i1a[7:0]];
    e.i2  = ref_mem[i2a[7:0]];
    e.d   = ref_mem[da[7:0]];
    e.cnt = exp_cnt;
    sb.push_back(e);
    last_pub = e;
  endtask

  // Drive one cycle (called at posedge+1), check the combinational memory
  // request, and return at the next posedge+1.
  task automatic phase(input logic [3:0] s, input logic we, input logic [15:0] exp_addr,
                       input logic exp_we, input string tag);
    stb  = s;
    d_we = we;
    #1;
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    check({tag, "_mem_we"}, 32'(mem_we), 32'(exp_we));
    if (exp_we) check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(d_wdata));
    @(posedge clk);
    #1;
  endtask

  task automatic legal_frame(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] ad,
                             input logic we, input logic [15:0] wd, input logic pub);
    i1a = a1; i2a = a2; da = ad; d_wdata = wd;
    phase(4'b1000, 1'b0, a1, 1'b0, "fr_i1");
    phase(4'b0100, 1'b0, a2, 1'b0, "fr_i2");
    phase(4'b0010, 1'b0, ad, 1'b0, "fr_d");
    if (pub) push_expected();
    phase(4'b0001, we, ad, pub & we, "fr_g");
    if (pub && we) ref_mem[ad[7:0]] = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1; stb = 4'b0000; d_we = 1'b0;
    @(posedge clk); #1;
    check("sb_drained_before_reset", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 8'd0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'hA000 | 16'(i);
      ref_mem[i] = 16'hA000 | 16'(i);
    end
    mem[8'h10] = 16'h1111; ref_mem[8'h10] = 16'h1111;
    mem[8'h20] = 16'h2222; ref_mem[8'h20] = 16'h2222;
    mem[8'h30] = 16'h3333; ref_mem[8'h30] = 16'h3333;

    //            stb      dwe   addr      we    sync  err   pub
    tbl[0]  = '{4'b0000, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b1100, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b1000, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{4'b0100, 1'b0, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'b0010, 1'b0, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{4'b0001, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{4'b1010, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{4'b1000, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{4'b0100, 1'b0, 16'h0020, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{4'b0110, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{4'b0001, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{4'b0011, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{4'b1111, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; stb = 4'b0000; d_we = 1'b0;
    i1a = '0; i2a = '0; da = '0; d_wdata = '0; exp_cnt = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: every output zero.
    check("rst_i1_data", 32'(i1_data), 32'd0);
    check("rst_i2_data", 32'(i2_data), 32'd0);
    check("rst_d_rdata", 32'(d_rdata), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_in_sync", 32'(in_sync), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;

    // Basic frame: 0x1111 / 0x2222 / 0x3333.
    legal_frame(16'h0010, 16'h0020, 16'h0030, 1'b0, 16'h0000, 1'b1);
    check("A_frame_valid", 32'(frame_valid), 32'd1);
    check("A_i1_data", 32'(i1_data), 32'h1111);
    check("A_i2_data", 32'(i2_data), 32'h2222);
    check("A_d_rdata", 32'(d_rdata), 32'h3333);
    check("A_frame_cnt", 32'(frame_cnt), 32'd1);
    check("A_in_sync", 32'(in_sync), 32'd1);

    // Write in gwe, then read-before-write and read-after-write frames.
    legal_frame(16'h0010, 16'h0020, 16'h0040, 1'b1, 16'hBEEF, 1'b1);
    check("W_mem_written", 32'(mem[8'h40]), 32'hBEEF);
    legal_frame(16'h0050, 16'h0020, 16'h0050, 1'b1, 16'h5A5A, 1'b1);
    legal_frame(16'h0010, 16'h0050, 16'h0040, 1'b0, 16'h0000, 1'b1);

    // Skipped i2: error, no write in the following gwe, then resync.
    i1a = 16'h0010; i2a = 16'h0020; da = 16'h0040; d_wdata = 16'h1234;
    phase(4'b1000, 1'b0, 16'h0010, 1'b0, "B_i1");
    phase(4'b0010, 1'b0, 16'h0040, 1'b0, "B_d_skip");
    check("B_seq_err", 32'(seq_err), 32'd1);
    check("B_in_sync", 32'(in_sync), 32'd0);
    phase(4'b0001, 1'b1, 16'h0040, 1'b0, "B_g_nowrite");
    check("B_frame_valid", 32'(frame_valid), 32'd0);
    check("B_mem_kept", 32'(mem[8'h40]), 32'(ref_mem[8'h40]));
    legal_frame(16'h0030, 16'h0010, 16'h0020, 1'b0, 16'h0000, 1'b1);
    check("B_resync_in_sync", 32'(in_sync), 32'd1);

    // i1re+dre together while in sync: error, published outputs hold.
    phase(4'b1010, 1'b0, 16'h0030, 1'b0, "C_multi");
    check("C_seq_err", 32'(seq_err), 32'd1);
    check("C_in_sync", 32'(in_sync), 32'd0);
    check("C_i1_hold", 32'(i1_data), 32'(last_pub.i1));
    check("C_i2_hold", 32'(i2_data), 32'(last_pub.i2));
    check("C_d_hold", 32'(d_rdata), 32'(last_pub.d));

    // Lone i1re in the wrong state ends in UNSYNC; resync on the next one.
    legal_frame(16'h0010, 16'h0020, 16'h0030, 1'b0, 16'h0000, 1'b1);
    phase(4'b1000, 1'b0, 16'h0010, 1'b0, "E_i1");
    phase(4'b1000, 1'b0, 16'h0010, 1'b0, "E_i1_again");
    check("E_in_sync", 32'(in_sync), 32'd0);
    legal_frame(16'h0020, 16'h0030, 16'h0010, 1'b0, 16'h0000, 1'b1);

    // Table-driven single-cycle vectors from a fresh reset.
    do_reset();
    i1a = 16'h0010; i2a = 16'h0020; da = 16'h0040; d_wdata = 16'hBEEF;
    for (int k = 0; k < 14; k++) begin
      if (tbl[k].pub) push_expected();
      phase(tbl[k].stb, tbl[k].dwe, tbl[k].exp_addr, tbl[k].exp_we, $sformatf("T%0d", k));
      if (tbl[k].pub && tbl[k].exp_we) ref_mem[da[7:0]] = d_wdata;
      check($sformatf("T%0d_in_sync", k), 32'(in_sync), 32'(tbl[k].exp_sync));
      check($sformatf("T%0d_seq_err", k), 32'(seq_err), 32'(tbl[k].exp_err));
    end

    // rst during the dre phase: no publish, outputs cleared, clean restart.
    do_reset();
    legal_frame(16'h0010, 16'h0020, 16'h0030, 1'b0, 16'h0000, 1'b1);
    phase(4'b1000, 1'b0, 16'h0010, 1'b0, "D_i1");
    phase(4'b0100, 1'b0, 16'h0020, 1'b0, "D_i2");
    rst = 1'b1;
    phase(4'b0010, 1'b0, 16'h0030, 1'b0, "D_d_rst");
    rst = 1'b0;
    exp_cnt = 8'd0;
    check("D_i1_data", 32'(i1_data), 32'd0);
    check("D_i2_data", 32'(i2_data), 32'd0);
    check("D_d_rdata", 32'(d_rdata), 32'd0);
    check("D_frame_valid", 32'(frame_valid), 32'd0);
    check("D_in_sync", 32'(in_sync), 32'd0);
    check("D_seq_err", 32'(seq_err), 32'd0);
    check("D_frame_cnt", 32'(frame_cnt), 32'd0);
    legal_frame(16'h0030, 16'h0020, 16'h0010, 1'b0, 16'h0000, 1'b1);
    check("D_restart_cnt", 32'(frame_cnt), 32'd1);

    // rst during a writing gwe: write suppressed, no publish.
    i1a = 16'h0010; i2a = 16'h0020; da = 16'h0060; d_wdata = 16'hDEAD;
    phase(4'b1000, 1'b0, 16'h0010, 1'b0, "R_i1");
    phase(4'b0100, 1'b0, 16'h0020, 1'b0, "R_i2");
    phase(4'b0010, 1'b0, 16'h0060, 1'b0, "R_d");
    rst = 1'b1;
    phase(4'b0001, 1'b1, 16'h0060, 1'b0, "R_g_rst");
    rst = 1'b0;
    exp_cnt = 8'd0;
    check("R_mem_kept", 32'(mem[8'h60]), 32'(ref_mem[8'h60]));
    check("R_frame_cnt", 32'(frame_cnt), 32'd0);

    // 256 legal frames: counter wraps to zero, no error.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      legal_frame(16'(i & 255), 16'((i + 1) & 255), 16'((i + 2) & 255),
                  (i % 3) == 0, 16'(i * 7 + 1), 1'b1);
    end
    check("F_frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    check("F_seq_err", 32'(seq_err), 32'd0);
    check("F_in_sync", 32'(in_sync), 32'd1);

    // Let the last prediction be consumed (bounded wait).
    rst = 1'b1; stb = 4'b0000;
    for (int w = 0; w < 4 && sb.size() != 0; w++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
